// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM state encoding
// and a compile-time max helper used to size the per-channel counters.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW    = 2'b00,
    WAIT_H = 2'b01,
    HIGH   = 2'b10,
    WAIT_L = 2'b11
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_tick_gen.sv
// Free-running divider producing a one-clock tick every TICK_DIV clocks.
// One instance is shared by every debounce channel.
module debounce_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] count;

  assign tick = (count == LAST);

  // Count 0..TICK_DIV-1, wrapping on the tick cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end

endmodule

// File: rtl/multi_debounce_fsm.sv
// N-channel push-button debouncer. Each channel synchronises its raw input,
// qualifies level changes over STABLE_TICKS shared ticks, and produces a
// registered debounced level, rise/fall pulses and a long-press held flag.
module multi_debounce_fsm
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 1_000_000,
  parameter int STABLE_TICKS = 3,
  parameter int HOLD_TICKS   = 100
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] deb,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] held
);

  localparam int CW = $clog2(max_int(STABLE_TICKS, HOLD_TICKS) + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [CW-1:0] HOLD_MAX    = CW'(HOLD_TICKS);
  localparam logic          HOLD_EN     = (HOLD_TICKS > 0);

  logic tick;

  debounce_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [1:0]    sync;
    logic          s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          deb_r, rise_r, fall_r, held_r;
    logic          deb_n, rise_n, fall_n, held_n;

    assign s = sync[1];

    // Two-flop synchroniser; the FSM only ever looks at s.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync <= '0;
      else       sync <= {sync[0], btn[g]};
    end

    // Channel state and tick counter.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= LOW;
        cnt   <= '0;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
      end
    end

    // Next state/counter; a level reversal in a wait state beats a tick.
    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
        LOW: begin
          if (s) begin
            state_n = WAIT_H;
            cnt_n   = '0;
          end
        end
        WAIT_H: begin
          if (!s) begin
            state_n = LOW;
            cnt_n   = '0;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state_n = HIGH;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        HIGH: begin
          if (!s) begin
            state_n = WAIT_L;
            cnt_n   = '0;
          end else if (tick && (cnt != HOLD_MAX)) begin
            cnt_n = cnt + 1'b1;
          end
        end
        WAIT_L: begin
          if (s) begin
            // Bounce back up: the hold period starts over.
            state_n = HIGH;
            cnt_n   = '0;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state_n = LOW;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
        default: begin
          state_n = LOW;
          cnt_n   = '0;
        end
      endcase
    end

    // Outputs derived from the state being entered so they land on that edge.
    always_comb begin
      deb_n  = (state_n == HIGH) || (state_n == WAIT_L);
      rise_n = (state_n == HIGH) && (state == WAIT_H);
      fall_n = (state_n == LOW)  && (state == WAIT_L);
      held_n = HOLD_EN && (state_n == HIGH) && (cnt_n == HOLD_MAX);
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        deb_r  <= 1'b0;
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        held_r <= 1'b0;
      end else begin
        deb_r  <= deb_n;
        rise_r <= rise_n;
        fall_r <= fall_n;
        held_r <= held_n;
      end
    end

    assign deb[g]  = deb_r;
    assign rise[g] = rise_r;
    assign fall[g] = fall_r;
    assign held[g] = held_r;
  end

endmodule

// File: tb/tb_multi_debounce_fsm.sv
// Bench for multi_debounce_fsm: expected rise/fall events (channel mask and
// cycle window) are queued when a button edge is driven and consumed when the
// DUT pulses; level outputs are spot-checked at fixed offsets.
module tb_multi_debounce_fsm;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N_CH-1:0] btn = '0;
  logic [N_CH-1:0] deb, rise, fall, held;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [N_CH-1:0] rise_m;
    logic [N_CH-1:0] fall_m;
    int              lo;
    int              hi;
  } ev_t;

  ev_t sb[$];

  multi_debounce_fsm #(
    .N_CH(N_CH), .TICK_DIV(4), .STABLE_TICKS(3), .HOLD_TICKS(5)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn),
    .deb(deb), .rise(rise), .fall(fall), .held(held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Edge driven now: pulse expected 11..15 clocks later.
  task automatic push_ev(input logic [N_CH-1:0] r, input logic [N_CH-1:0] f);
    ev_t e;
    e.rise_m = r;
    e.fall_m = f;
    e.lo     = cyc + 11;
    e.hi     = cyc + 15;
    sb.push_back(e);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_deb"},  32'(deb),  0);
    chk({tag, "_held"}, 32'(held), 0);
    chk({tag, "_rise"}, 32'(rise), 0);
    chk({tag, "_fall"}, 32'(fall), 0);
  endtask

  // Pulse monitor: every rise/fall cycle must match the oldest queued event.
  always @(negedge clk) begin
    if (!reset && ((rise | fall) != '0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 32'({rise, fall}), 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("rise_mask", 32'(rise), 32'(e.rise_m));
        chk("fall_mask", 32'(fall), 32'(e.fall_m));
        chk("pulse_in_window", 32'((cyc >= e.lo) && (cyc <= e.hi)), 1);
      end
    end
  end

  initial begin
    // Reset state
    wait_clk(3);
    chk_zero("reset");
    reset = 1'b0;
    wait_clk(5);
    chk_zero("post_reset");

    // Clean press on ch0
    btn[0] = 1'b1; push_ev(4'b0001, 4'b0000);
    wait_clk(10);
    chk("clean_deb_early", 32'(deb), 0);
    wait_clk(30);
    chk("clean_deb", 32'(deb), 32'h1);
    chk("clean_held", 32'(held), 32'h1);
    btn[0] = 1'b0; push_ev(4'b0000, 4'b0001);
    wait_clk(4);
    chk("clean_held_clr", 32'(held), 0);
    chk("clean_deb_wait_l", 32'(deb), 32'h1);
    wait_clk(20);
    chk("clean_deb_off", 32'(deb), 0);

    // Bounce on ch1: 3-clock pulses never qualify
    for (int k = 0; k < 10; k++) begin
      btn[1] = (k % 2 == 0);
      wait_clk(3);
      if (k == 5) chk("bounce_deb_mid", 32'(deb), 0);
    end
    chk("bounce_deb_end", 32'(deb), 0);
    btn[1] = 1'b1; push_ev(4'b0010, 4'b0000);
    wait_clk(16);
    chk("bounce_deb", 32'(deb), 32'h2);
    btn[1] = 1'b0; push_ev(4'b0000, 4'b0010);
    wait_clk(20);

    // Release glitch on ch2
    btn[2] = 1'b1; push_ev(4'b0100, 4'b0000);
    wait_clk(40);
    chk("glitch_held_pre", 32'(held), 32'h4);
    btn[2] = 1'b0;
    wait_clk(4);
    chk("glitch_held_drop", 32'(held), 0);
    chk("glitch_deb_mid", 32'(deb), 32'h4);
    wait_clk(1);
    btn[2] = 1'b1;
    wait_clk(10);
    chk("glitch_held_restart", 32'(held), 0);
    chk("glitch_deb", 32'(deb), 32'h4);
    wait_clk(25);
    chk("glitch_held_again", 32'(held), 32'h4);
    btn[2] = 1'b0; push_ev(4'b0000, 4'b0100);
    wait_clk(20);

    // Long press on ch3
    btn[3] = 1'b1; push_ev(4'b1000, 4'b0000);
    wait_clk(28);
    chk("long_deb", 32'(deb), 32'h8);
    chk("long_held_early", 32'(held), 0);
    wait_clk(12);
    chk("long_held", 32'(held), 32'h8);
    wait_clk(20);
    btn[3] = 1'b0; push_ev(4'b0000, 4'b1000);
    wait_clk(4);
    chk("long_held_clr", 32'(held), 0);
    wait_clk(20);
    chk("long_deb_off", 32'(deb), 0);

    // Simultaneous edges on ch0 and ch3
    btn = 4'b1001; push_ev(4'b1001, 4'b0000);
    wait_clk(20);
    chk("simul_deb", 32'(deb), 32'h9);
    btn = 4'b0000; push_ev(4'b0000, 4'b1001);
    wait_clk(20);

    // Reset while ch0 is in WAIT_H
    btn[0] = 1'b1;
    wait_clk(6);
    chk("rst_wh_deb", 32'(deb), 0);
    @(posedge clk); #2 reset = 1'b1;
    #1 chk_zero("rst_wh");
    btn[0] = 1'b0;
    @(negedge clk); reset = 1'b0;
    wait_clk(20);
    chk_zero("rst_wh_after");

    // Reset while ch1 is in HIGH with held set
    btn[1] = 1'b1; push_ev(4'b0010, 4'b0000);
    wait_clk(40);
    chk("rst_hi_deb_pre", 32'(deb), 32'h2);
    chk("rst_hi_held_pre", 32'(held), 32'h2);
    @(posedge clk); #2 reset = 1'b1;
    #1 chk_zero("rst_hi");
    btn[1] = 1'b0;
    @(negedge clk); reset = 1'b0;
    wait_clk(30);
    chk_zero("rst_hi_after");

    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
